// File: rtl/genius_disp_pkg.sv
// ----------------------------------------------------------------------------
// genius_disp_pkg
//   Shared constants for the Genius score display path.
//   - ST_SHOW / ST_OVER / ST_WIN : display FSM state encoding (2 bits)
//   - CODE_W                     : width of the 7-segment decoder input code
//   - CODE_ERR_DFLT              : decoder code for the error ("Er") pattern
//   - CODE_WIN_DFLT              : decoder code for the win ("SS") pattern
// ----------------------------------------------------------------------------
package genius_disp_pkg;

    localparam int CODE_W = 6;

    localparam logic [1:0] ST_SHOW = 2'd0;
    localparam logic [1:0] ST_OVER = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;

    localparam logic [CODE_W-1:0] CODE_ERR_DFLT = 6'd33;
    localparam logic [CODE_W-1:0] CODE_WIN_DFLT = 6'd34;

endpackage

// File: rtl/blink_tick_gen.sv
// ----------------------------------------------------------------------------
// blink_tick_gen
//   Free-running 0..BLINK_CYC-1 counter used to pace the display flash.
//   Ports:
//     clk    in  1  system clock, rising edge
//     rst_n  in  1  asynchronous active-low reset
//     en     in  1  count enable (high while a flashing state is active)
//     clr    in  1  synchronous clear, wins over en
//     tick   out 1  high for the cycle in which the counter wraps
//   tick is decoded from the counter so the consumer toggles on the same
//   edge the counter returns to zero.
// ----------------------------------------------------------------------------
module blink_tick_gen #(
    parameter int BLINK_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    // Wrap detection: only a counting, non-cleared cycle can wrap.
    always_comb begin
        wrap_s = en && !clr && (cnt_r == CNT_LAST);
    end

    // Flash period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = wrap_s;

endmodule

// File: rtl/score_display_ctrl.sv
// ----------------------------------------------------------------------------
// score_display_ctrl
//   Keeps the Genius player score and sequences the two-digit 7-segment
//   decoder: SHOW displays the score, OVER flashes the error code, WIN
//   flashes the win code.
//   Ports:
//     clk         in  1  system clock, rising edge
//     rst_n       in  1  asynchronous active-low reset
//     score_inc   in  1  pulse: round won, score +1
//     score_clr   in  1  pulse: new game, score = 0, back to SHOW
//     game_over   in  1  pulse: player error, enter OVER
//     disp_code   out 6  decoder code, registered
//     disp_blank  out 1  force decoder outputs off, registered
//     state_o     out 2  FSM state (0 SHOW, 1 OVER, 2 WIN), registered
//   Build option: define DISP_BLINK_EN to enable flashing in OVER/WIN.
//   Without it OVER shows CODE_ERR and WIN shows CODE_WIN steadily.
//   Event priority: score_clr > game_over > score_inc.
//   Outputs are decoded from the registered state, so an event taken at
//   one edge becomes visible after the following edge.
// ----------------------------------------------------------------------------
module score_display_ctrl
    import genius_disp_pkg::*;
#(
    parameter int                CLK_HZ    = 50_000_000,
    parameter int                BLINK_MS  = 500,
    parameter int                MAX_SCORE = 32,
    parameter logic [CODE_W-1:0] CODE_ERR  = CODE_ERR_DFLT,
    parameter logic [CODE_W-1:0] CODE_WIN  = CODE_WIN_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              score_inc,
    input  logic              score_clr,
    input  logic              game_over,
    output logic [CODE_W-1:0] disp_code,
    output logic              disp_blank,
    output logic [1:0]        state_o
);

    localparam logic [CODE_W-1:0] SCORE_MAX  = CODE_W'(MAX_SCORE);
    localparam logic [CODE_W-1:0] SCORE_LAST = CODE_W'(MAX_SCORE - 1);
    localparam logic [CODE_W-1:0] SCORE_ONE  = CODE_W'(1);

    logic [CODE_W-1:0] score_r;
    logic [CODE_W-1:0] score_nxt_s;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              phase_s;
    logic [CODE_W-1:0] code_s;
    logic              blank_s;

    // Next score / state from the event pulses, highest priority first.
    always_comb begin
        score_nxt_s = score_r;
        state_nxt_s = state_r;
        if (score_clr) begin
            score_nxt_s = '0;
            state_nxt_s = ST_SHOW;
        end else begin
            case (state_r)
                ST_SHOW: begin
                    if (game_over) begin
                        state_nxt_s = ST_OVER;
                    end else if (score_inc) begin
                        if (score_r < SCORE_LAST) begin
                            score_nxt_s = score_r + SCORE_ONE;
                        end else begin
                            // Reaching the limit saturates and wins.
                            score_nxt_s = SCORE_MAX;
                            state_nxt_s = ST_WIN;
                        end
                    end else begin
                        score_nxt_s = score_r;
                    end
                end
                ST_OVER: begin
                    state_nxt_s = ST_OVER;
                end
                ST_WIN: begin
                    state_nxt_s = ST_WIN;
                end
                default: begin
                    // Unreachable encoding: recover to a clean new game.
                    score_nxt_s = '0;
                    state_nxt_s = ST_SHOW;
                end
            endcase
        end
    end

    // Score and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r <= '0;
            state_r <= ST_SHOW;
        end else begin
            score_r <= score_nxt_s;
            state_r <= state_nxt_s;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BLINK_CYC = (CLK_HZ / 1000) * BLINK_MS;

    logic flash_en_s;
    logic flash_clr_s;
    logic tick_s;
    logic phase_r;

    // Flash timing runs only in OVER/WIN and restarts on entry or new game.
    always_comb begin
        flash_en_s  = (state_r == ST_OVER) || (state_r == ST_WIN);
        flash_clr_s = score_clr ||
                      ((state_nxt_s != state_r) && (state_nxt_s != ST_SHOW));
    end

    blink_tick_gen #(
        .BLINK_CYC (BLINK_CYC)
    ) u_blink_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flash_en_s),
        .clr   (flash_clr_s),
        .tick  (tick_s)
    );

    // Flash phase: toggles once per counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
        end else if (flash_clr_s) begin
            phase_r <= 1'b0;
        end else if (tick_s) begin
            phase_r <= ~phase_r;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Phase seen by the display decode.
    always_comb begin
        phase_s = phase_r;
    end
`else
    // Steady display: the phase never leaves 0.
    always_comb begin
        phase_s = 1'b0;
    end
`endif

    // Display decode from the registered state.
    always_comb begin
        code_s  = score_r;
        blank_s = 1'b0;
        case (state_r)
            ST_SHOW: begin
                // Guard: never hand the decoder a code above the win pattern.
                if (score_r > CODE_WIN) begin
                    code_s = CODE_ERR;
                end else begin
                    code_s = score_r;
                end
            end
            ST_OVER: begin
                if (phase_s) begin
                    code_s = score_r;
                end else begin
                    code_s = CODE_ERR;
                end
            end
            ST_WIN: begin
                code_s  = CODE_WIN;
                blank_s = phase_s;
            end
            default: begin
                code_s  = CODE_ERR;
                blank_s = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_code  <= '0;
            disp_blank <= 1'b0;
            state_o    <= ST_SHOW;
        end else begin
            disp_code  <= code_s;
            disp_blank <= blank_s;
            state_o    <= state_r;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_score_display_ctrl
//   Randomized and directed stimulus for score_display_ctrl, compared each
//   cycle against a behavioural model (score, mode, cycles spent flashing).
//   Works with or without DISP_BLINK_EN.
// ----------------------------------------------------------------------------
module tb_score_display_ctrl;

    localparam int BLINK_CYC = 4;

    logic       clk;
    logic       rst_n;
    logic       score_inc;
    logic       score_clr;
    logic       game_over;
    logic [5:0] disp_code;
    logic       disp_blank;
    logic [1:0] state_o;

    int checks;
    int errors;

    // Model: 0 SHOW, 1 OVER, 2 WIN
    int m_score;
    int m_mode;
    int m_flash_cyc;
    int exp_code;
    int exp_blank;
    int exp_state;

    score_display_ctrl #(
        .CLK_HZ    (1000),
        .BLINK_MS  (4),
        .MAX_SCORE (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .score_inc  (score_inc),
        .score_clr  (score_clr),
        .game_over  (game_over),
        .disp_code  (disp_code),
        .disp_blank (disp_blank),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score     = 0;
        m_mode      = 0;
        m_flash_cyc = 0;
        exp_code    = 0;
        exp_blank   = 0;
        exp_state   = 0;
    endtask

    // What the display should show for the current model state.
    task automatic model_view(output int code, output int blank, output int st);
        int phase;
        phase = (m_flash_cyc / BLINK_CYC) % 2;
`ifndef DISP_BLINK_EN
        phase = 0;
`endif
        st    = m_mode;
        blank = 0;
        if (m_mode == 0) begin
            code = m_score;
        end else if (m_mode == 1) begin
            code = (phase == 1) ? m_score : 33;
        end else begin
            code  = 34;
            blank = phase;
        end
    endtask

    task automatic model_update(input bit inc, input bit clr, input bit ovr);
        if (clr) begin
            m_score = 0; m_mode = 0; m_flash_cyc = 0;
        end else if (ovr && m_mode == 0) begin
            m_mode = 1; m_flash_cyc = 0;
        end else if (inc && m_mode == 0) begin
            if (m_score == 31) begin
                m_score = 32; m_mode = 2; m_flash_cyc = 0;
            end else begin
                m_score = m_score + 1;
            end
        end else if (m_mode != 0) begin
            m_flash_cyc = m_flash_cyc + 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".code"},  int'(disp_code),  exp_code);
        check_eq({tag, ".blank"}, int'(disp_blank), exp_blank);
        check_eq({tag, ".state"}, int'(state_o),    exp_state);
    endtask

    // One clock with the given pulses, then compare against the model.
    task automatic step(input bit inc, input bit clr, input bit ovr, input string tag);
        score_inc = inc;
        score_clr = clr;
        game_over = ovr;
        @(posedge clk);
        model_view(exp_code, exp_blank, exp_state);
        model_update(inc, clr, ovr);
        #1;
        score_inc = 1'b0;
        score_clr = 1'b0;
        game_over = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        score_inc = 1'b0;
        score_clr = 1'b0;
        game_over = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        #3 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, "idle0");

        // 1) five increments
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "inc5");
        step(1'b0, 1'b0, 1'b0, "inc5_idle");
        check_eq("inc5_value", int'(disp_code), 5);
        check_eq("inc5_state", int'(state_o), 0);

        // 2) saturate and win, then one more increment
        step(1'b0, 1'b1, 1'b0, "clr2");
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, "inc32");
        step(1'b0, 1'b0, 1'b0, "win_idle");
        check_eq("win_state", int'(state_o), 2);
        check_eq("win_code", int'(disp_code), 34);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, "win_flash");
        step(1'b1, 1'b0, 1'b0, "inc33");
        check_eq("inc33_score", m_score, 32);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, "win_flash2");

        // 3) game over at score 7, increment ignored
        step(1'b0, 1'b1, 1'b0, "clr3");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, "inc7");
        step(1'b0, 1'b0, 1'b1, "over");
        step(1'b0, 1'b0, 1'b0, "over_idle");
        check_eq("over_code", int'(disp_code), 33);
        check_eq("over_state", int'(state_o), 1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, "over_flash");
        step(1'b1, 1'b0, 1'b0, "over_inc");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, "over_flash2");

        // 4) all three events together from score 9
        step(1'b0, 1'b1, 1'b0, "clr4");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "inc9");
        step(1'b1, 1'b1, 1'b1, "all3");
        step(1'b0, 1'b0, 1'b0, "all3_idle");
        check_eq("all3_code", int'(disp_code), 0);
        check_eq("all3_state", int'(state_o), 0);

        // 5) asynchronous reset during OVER phase 1
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, "inc7b");
        step(1'b0, 1'b0, 1'b1, "over5");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, "over5_flash");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        #3 rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, "post_rst_inc");
        step(1'b0, 1'b0, 1'b0, "post_rst_idle");
        check_eq("post_rst_value", int'(disp_code), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit r_inc, r_clr, r_ovr;
            r_inc = ($urandom_range(1, 0) == 1);
            r_clr = ($urandom_range(39, 0) == 0);
            r_ovr = ($urandom_range(24, 0) == 0);
            step(r_inc, r_clr, r_ovr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
